// File: rtl/hazard_pkg.sv
// Shared types and encodings for the ID-stage hazard / stall controller.
// Register width, forward-select codes, FSM states, tracker entry.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_t;

    localparam reg_t REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_FLUSH
    } state_e;

    typedef struct packed {
        logic valid;
        reg_t rd;
        logic load;
    } trk_entry_t;

    // Tracker index 0 is EX; older entries sit further down the pipe.
    function automatic logic [1:0] fwd_sel(input int k);
        if (k == 0)
            return FWD_EX;
        else if (k == 1)
            return FWD_MEM;
        else
            return FWD_WB;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side bundle between ID and the hazard controller.
// master = decode/pipeline side, slave = controller.
interface hazard_stall_ctrl_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             id_valid;
    reg_t             id_rs;
    reg_t             id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    reg_t             id_rd;
    logic             id_wr;
    logic             id_load;
    logic             br_taken;

    logic             stall;
    logic             bubble;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_rd, id_wr, id_load, br_taken,
        input  stall, bubble, flush, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_rd, id_wr, id_load, br_taken,
        output stall, bubble, flush, fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/reg_hazard_match.sv
// One source register vs one tracker entry.
// Register 0 never matches.
module reg_hazard_match
    import hazard_pkg::*;
(
    input  reg_t src,
    input  logic use_src,
    input  logic ent_valid,
    input  reg_t ent_rd,
    output logic hit
);

    assign hit = use_src & ent_valid
               & (src == ent_rd)
               & (src != REG_ZERO);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID issue sequencer: tracker, hazard detect, stall/bubble/flush, stall counter.
// Build option HAZARD_FWD_EN: load-use-only hazards plus forward selects.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYC - 1);

    trk_entry_t       trk [DEPTH];
    trk_entry_t       ins;
    logic [DEPTH-1:0] hit_rs;
    logic [DEPTH-1:0] hit_rt;
    logic             active;
    logic             hazard;
    logic             br;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    state_e           state;
    state_e           state_nxt;
    logic [1:0]       fl_left;
    logic [1:0]       fl_nxt;
    logic [CNT_W-1:0] cnt;

    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        reg_hazard_match u_rs (
            .src       (bus.id_rs),
            .use_src   (bus.id_use_rs),
            .ent_valid (trk[k].valid),
            .ent_rd    (trk[k].rd),
            .hit       (hit_rs[k])
        );
        reg_hazard_match u_rt (
            .src       (bus.id_rt),
            .use_src   (bus.id_use_rt),
            .ent_valid (trk[k].valid),
            .ent_rd    (trk[k].rd),
            .hit       (hit_rt[k])
        );
    end

    // Outputs stay quiet until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            active <= 1'b0;
        else
            active <= 1'b1;
    end

`ifdef HAZARD_FWD_EN
    assign hazard = (hit_rs[0] | hit_rt[0]) & trk[0].load;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_rs[k])
                fwd_a = fwd_sel(k);
            if (hit_rt[k])
                fwd_b = fwd_sel(k);
        end
    end
`else
    assign hazard = |(hit_rs | hit_rt);
    assign fwd_a  = FWD_RF;
    assign fwd_b  = FWD_RF;
`endif

    assign br     = active & bus.br_taken;
    // The branch cycle itself is the first flush cycle.
    assign flush  = br | (state == S_FLUSH);
    assign stall  = active & hazard & bus.id_valid & ~flush;
    assign bubble = stall | flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RUN;
            fl_left <= 2'd0;
        end else begin
            state   <= state_nxt;
            fl_left <= fl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fl_nxt    = fl_left;
        if (br) begin
            fl_nxt    = FL_INIT;
            state_nxt = (FL_INIT != 2'd0) ? S_FLUSH : S_RUN;
        end else begin
            unique case (state)
                S_FLUSH: begin
                    fl_nxt = fl_left - 2'd1;
                    if (fl_left <= 2'd1) begin
                        fl_nxt    = 2'd0;
                        state_nxt = S_RUN;
                    end
                end
                S_RUN, S_STALL: begin
                    state_nxt = stall ? S_STALL : S_RUN;
                end
                default: begin
                    state_nxt = S_RUN;
                    fl_nxt    = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        ins.valid = active & bus.id_valid & bus.id_wr
                  & ~bubble & ~flush;
        ins.rd    = bus.id_rd;
        ins.load  = bus.id_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                trk[k] <= '0;
        end else begin
            trk[0] <= ins;
            for (int k = 1; k < DEPTH; k++)
                trk[k] <= trk[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (stall && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign bus.stall     = stall;
    assign bus.bubble    = bubble;
    assign bus.flush     = flush;
    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios then random traffic vs a model.
// Follows the HAZARD_FWD_EN build setting of the design.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam int DEPTH     = 3;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(
        .DEPTH     (DEPTH),
        .FLUSH_CYC (FLUSH_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: list of in-flight writers by age (0 = youngest), plus counters.
    bit m_act;
    bit m_v  [DEPTH];
    int m_rd [DEPTH];
    bit m_ld [DEPTH];
    int m_flen;
    int m_cnt;

    bit e_stall, e_bubble, e_flush;
    int e_fa, e_fb;
    bit o_stall, o_flush;
    int o_fa, o_fb;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit hit(input int src, input bit u, input int k);
        return u && m_v[k] && (src != 0) && (m_rd[k] == src);
    endfunction

    task automatic model_clear();
        m_act  = 1'b0;
        m_flen = 0;
        m_cnt  = 0;
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k]  = 1'b0;
            m_rd[k] = 0;
            m_ld[k] = 1'b0;
        end
    endtask

    task automatic model_eval();
        bit hz;
        int fa, fb;
        hz = 1'b0;
        fa = 0;
        fb = 0;
        if (FWD) begin
            hz = m_ld[0] && (hit(bus.id_rs, bus.id_use_rs, 0)
                          || hit(bus.id_rt, bus.id_use_rt, 0));
            for (int k = 0; k < DEPTH; k++) begin
                if (fa == 0 && hit(bus.id_rs, bus.id_use_rs, k)) fa = k + 1;
                if (fb == 0 && hit(bus.id_rt, bus.id_use_rt, k)) fb = k + 1;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (hit(bus.id_rs, bus.id_use_rs, k) || hit(bus.id_rt, bus.id_use_rt, k))
                    hz = 1'b1;
        end
        e_flush  = m_act && (bus.br_taken || m_flen > 0);
        e_stall  = m_act && hz && bus.id_valid && !e_flush;
        e_bubble = e_stall || e_flush;
        e_fa     = fa;
        e_fb     = fb;
    endtask

    task automatic model_step();
        bit nv;
        if (!rst_n) begin
            model_clear();
        end else begin
            nv = m_act && bus.id_valid && bus.id_wr && !e_bubble && !e_flush;
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_v[k]  = m_v[k-1];
                m_rd[k] = m_rd[k-1];
                m_ld[k] = m_ld[k-1];
            end
            m_v[0]  = nv;
            m_rd[0] = bus.id_rd;
            m_ld[0] = bus.id_load;
            if (e_stall && m_cnt < CNT_MAX) m_cnt++;
            if (m_act && bus.br_taken) m_flen = FLUSH_CYC - 1;
            else if (m_flen > 0) m_flen--;
            m_act = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall",     32'(bus.stall),     32'(e_stall));
        chk("bubble",    32'(bus.bubble),    32'(e_bubble));
        chk("flush",     32'(bus.flush),     32'(e_flush));
        chk("fwd_a",     32'(bus.fwd_a),     32'(e_fa));
        chk("fwd_b",     32'(bus.fwd_b),     32'(e_fb));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        check_all();
        o_stall = bus.stall;
        o_flush = bus.flush;
        o_fa    = int'(bus.fwd_a);
        o_fb    = int'(bus.fwd_b);
        @(posedge clk);
        model_eval();
        model_step();
        #1;
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                          input bit urt, input int rd, input bit wr, input bit ld);
        bus.id_valid  = v;
        bus.id_rs     = 5'(rs);
        bus.id_rt     = 5'(rt);
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_rd     = 5'(rd);
        bus.id_wr     = wr;
        bus.id_load   = ld;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.br_taken = 1'b0;
        repeat (n) cycle();
    endtask

    // Hold one instruction in ID until the model lets it go; count observed stalls.
    task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                         input int rd, input bit wr, input bit ld, output int nst);
        bit done;
        set_id(1, rs, rt, urs, urt, rd, wr, ld);
        nst  = 0;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            cycle();
            if (o_stall) nst++;
            if (!e_stall) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $error("FAIL issue_timeout: observed still stalled expected release");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nfl;

        rst_n = 1'b0;
        idle(0);
        model_clear();
        @(negedge clk);
        model_eval();
        check_all();
        @(posedge clk);
        model_step();
        #1;
        rst_n = 1'b1;
        idle(3);

        // lw r5 ; add r6,r5,r1
        issue(1, 0, 1, 0, 5, 1, 1, n);
        issue(5, 1, 1, 1, 6, 1, 0, n);
        chk("t1_stall_cycles", 32'(n), FWD ? 32'd1 : 32'd3);

        // add r3 ; sub r4,r3,r3
        idle(3);
        issue(1, 2, 1, 1, 3, 1, 0, n);
        issue(3, 3, 1, 1, 4, 1, 0, n);
        chk("t2_stall_cycles", 32'(n), FWD ? 32'd0 : 32'd3);
        chk("t2_fwd_a", 32'(o_fa), FWD ? 32'd1 : 32'd0);
        chk("t2_fwd_b", 32'(o_fb), FWD ? 32'd1 : 32'd0);

        // write r0 then read r0
        idle(3);
        issue(1, 0, 1, 0, 0, 1, 1, n);
        issue(0, 0, 1, 1, 7, 1, 0, n);
        chk("t3_stall_cycles", 32'(n), 32'd0);
        chk("t3_fwd_a", 32'(o_fa), 32'd0);
        chk("t3_fwd_b", 32'(o_fb), 32'd0);

        // taken branch on top of a load-use hazard
        idle(3);
        issue(1, 0, 1, 0, 5, 1, 1, n);
        set_id(1, 5, 0, 1, 0, 6, 1, 0);
        bus.br_taken = 1'b1;
        cycle();
        chk("t4_flush", 32'(o_flush), 32'd1);
        chk("t4_stall", 32'(o_stall), 32'd0);
        bus.br_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        nfl = 0;
        repeat (3) begin
            cycle();
            if (o_flush) nfl++;
        end
        chk("t4_flush_tail", 32'(nfl), 32'(FLUSH_CYC - 1));

        // repeated hazards drive the counter into saturation
        idle(3);
        for (int i = 0; i < 20; i++) begin
            issue(1, 0, 1, 0, 3, 1, 1, n);
            issue(3, 0, 1, 0, 6, 1, 0, n);
        end
        chk("t5_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));
        issue(1, 0, 1, 0, 3, 1, 1, n);
        issue(3, 0, 1, 0, 6, 1, 0, n);
        chk("t5_hold", 32'(bus.stall_cnt), 32'(CNT_MAX));

        // async reset in the middle of a stall
        idle(3);
        issue(1, 0, 1, 0, 5, 1, 1, n);
        set_id(1, 5, 0, 1, 0, 6, 1, 0);
        @(negedge clk);
        model_eval();
        check_all();
        chk("t6_pre_stall", 32'(bus.stall), 32'd1);
        #1;
        rst_n = 1'b0;
        bus.br_taken = 1'b1;
        #1;
        model_clear();
        model_eval();
        check_all();
        chk("t6_async_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        model_eval();
        model_step();
        #1;
        cycle();
        rst_n = 1'b1;
        bus.br_taken = 1'b0;
        cycle();
        cycle();
        chk("t6_tracker_cleared", 32'(o_stall), 32'd0);

        // random traffic on a small register range to provoke overlaps
        idle(3);
        for (int i = 0; i < 600; i++) begin
            if (!e_stall)
                set_id($urandom_range(0, 3) != 0,
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0);
            bus.br_taken = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
